fetch_stage: RTL

- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Holds the PC, drives the instruction-memory address and owns the IF/ID pipeline register.
- Consumes the PcWrite/IFIDWrite stall enables from hazard detection and the branch/jump redirect from ID.
- Presents instr2 and its PC+4 to the ID stage and hazard detection; keeps stall and flush counters for debug.

---
 rtl/fetch_stage.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Holds the PC, drives the instruction-memory address, owns the IF/ID
// register and keeps saturating stall/flush counters for debug.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PcWrite,
    input  logic             IFIDWrite,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ready,
    output logic [31:0]      instr2,
    output logic [31:0]      pc4_2,
    output logic             valid2,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [31:0]      pc_r;
    logic [31:0]      pcPlus4_s;
    logic [31:0]      target_s;
    logic             redirect_s;
    logic [31:0]      instr_r;
    logic [31:0]      pc4_r;
    logic             valid_r;
    logic [CNT_W-1:0] stallCnt_r;
    logic [CNT_W-1:0] flushCnt_r;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (&value) begin
            result = value;
        end else begin
            result = value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

    // Redirect decode: a branch/jump is only final when ID is not stalled.
    always_comb begin
        pcPlus4_s  = pc_r + 32'd4;
        redirect_s = PcWrite & (branch_taken | jump);
        target_s   = 32'h00000000;
        if (branch_taken) begin
            target_s = {branch_target[31:2], 2'b00};
        end else begin
            target_s = {jump_target[31:2], 2'b00};
        end
    end

    // Program counter: redirect beats sequential advance, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else if (redirect_s) begin
            pc_r <= target_s;
        end else if (PcWrite && imem_ready) begin
            pc_r <= pcPlus4_s;
        end else begin
            pc_r <= pc_r;
        end
    end

    // IF/ID register: flush on redirect even when stalled, else hold/load/bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_r <= 32'h00000000;
            pc4_r   <= 32'h00000000;
            valid_r <= 1'b0;
        end else if (redirect_s) begin
            instr_r <= 32'h00000000;
            pc4_r   <= 32'h00000000;
            valid_r <= 1'b0;
        end else if (!IFIDWrite) begin
            instr_r <= instr_r;
            pc4_r   <= pc4_r;
            valid_r <= valid_r;
        end else if (imem_ready) begin
            instr_r <= imem_rdata;
            pc4_r   <= pcPlus4_s;
            valid_r <= 1'b1;
        end else begin
            instr_r <= 32'h00000000;
            pc4_r   <= 32'h00000000;
            valid_r <= 1'b0;
        end
    end

    // Debug counters: a redirect counts as a flush, never as a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt_r <= {CNT_W{1'b0}};
            flushCnt_r <= {CNT_W{1'b0}};
        end else if (redirect_s) begin
            stallCnt_r <= stallCnt_r;
            flushCnt_r <= satInc(flushCnt_r);
        end else if (!IFIDWrite) begin
            stallCnt_r <= satInc(stallCnt_r);
            flushCnt_r <= flushCnt_r;
        end else begin
            stallCnt_r <= stallCnt_r;
            flushCnt_r <= flushCnt_r;
        end
    end

    assign imem_addr = pc_r;
    assign instr2    = instr_r;
    assign pc4_2     = pc4_r;
    assign valid2    = valid_r;
    assign stall_cnt = stallCnt_r;
    assign flush_cnt = flushCnt_r;

endmodule
